// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - IO-mapped 8N1 UART transmitter with byte buffer and programmable bit rate
//
// Responder on the MMU IO port. Software pushes bytes to TXDATA; the serialiser
// sends them LSB first, one start bit and one stop bit, at DIVISOR+1 clocks per bit.
//
// Build option: define IO_UART_TX_FIFO_EN for a FIFO of depth 2**FIFO_AW; without it
// a single-entry holding register buffers one byte.
//
// Parameters:
//   BASE_ADDR     block selected when io_addr[7:4] == BASE_ADDR[7:4]
//   DEFAULT_DIV   reset value of DIVISOR (clocks per bit minus 1)
//   FIFO_AW       FIFO address width (FIFO build only)
//
// Ports:
//   clk            clock, all state on rising edge
//   resetb         asynchronous active-low reset
//   io_addr[7:0]   byte address; [3:2] selects register, [1:0] ignored
//   io_en          access strobe
//   io_we          1 = write, 0 = read (qualified by io_en)
//   io_data_write  write data
//   io_data_read   combinational read data, 0 when not selected
//   txd            serial output, idle high
//
// Register map (offset from base):
//   0x0 TXDATA  W  push [7:0]; reads 0
//   0x4 STATUS  R  [0] busy [1] full [2] empty [3] overflow [15:8] count; any write clears overflow
//   0x8 DIVISOR RW [15:0]
//   0xC CTRL    RW [0] enable, [1] flush (write-1 pulse, reads 0)

module io_uart_tx #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter logic [15:0] DEFAULT_DIV = 16'd867,
    parameter int          FIFO_AW     = 3
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    output logic        txd
);

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       wr;
    logic [1:0] reg_idx;
    logic       push;
    logic       flush;
    logic       pop;
    logic       push_ok;

    assign sel     = (io_addr[7:4] == BASE_ADDR[7:4]);
    assign wr      = sel & io_en & io_we;
    assign reg_idx = io_addr[3:2];
    assign push    = wr && (reg_idx == REG_TXDATA);
    assign flush   = wr && (reg_idx == REG_CTRL) && io_data_write[1];

    logic unused_bits;
    assign unused_bits = ^{io_addr[1:0], io_data_write[31:16], BASE_ADDR[3:0]};

    // ------------------------------------------------------------------
    // Byte buffer
    // ------------------------------------------------------------------
    logic             full;
    logic             empty;
    logic [7:0]       head;
    logic [FIFO_AW:0] count;

    // A pop in the same cycle frees a slot, so a push into a full buffer is
    // still accepted then. Flush discards everything including this push.
    assign push_ok = push && !flush && (!full || pop);

`ifdef IO_UART_TX_FIFO_EN
    localparam int DEPTH = 1 << FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    assign full  = (count == (FIFO_AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= io_data_write[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // The head byte popped this cycle is still captured by the serialiser.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       hold_valid;

    assign full  = hold_valid;
    assign empty = !hold_valid;
    assign head  = hold;
    assign count = (FIFO_AW + 1)'(hold_valid);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            hold       <= '0;
            hold_valid <= 1'b0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (push_ok) begin
            // Also covers push-while-popping: the old byte leaves, the new one stays.
            hold       <= io_data_write[7:0];
            hold_valid <= 1'b1;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [15:0] divisor;
    logic        enable;
    logic        overflow;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            divisor  <= DEFAULT_DIV;
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr && (reg_idx == REG_DIVISOR)) begin
                divisor <= io_data_write[15:0];
            end
            if (wr && (reg_idx == REG_CTRL)) begin
                enable <= io_data_write[0];
            end
            if (wr && (reg_idx == REG_STATUS)) begin
                overflow <= 1'b0;
            end else if (push && !flush && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t      state;
    state_t      next_state;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tick;
    logic        busy;

    // bit_cnt counts down from DIVISOR; the bit ends when it reaches zero.
    assign tick = (bit_cnt == '0);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable && !empty) begin
                    next_state = S_START;
                    pop        = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (tick && (bit_idx == 3'd7)) begin
                    next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (enable && !empty) begin
                        next_state = S_START;
                        pop        = 1'b1;
                    end else begin
                        next_state = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Reload from the live DIVISOR at every bit boundary, so a write lands
    // on the next bit rather than the next frame.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else if (pop) begin
            shift   <= head;
            bit_idx <= '0;
            bit_cnt <= divisor;
        end else if (state != S_IDLE) begin
            if (tick) begin
                bit_cnt <= divisor;
                if (state == S_DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_cnt <= bit_cnt - 16'd1;
            end
        end
    end

    // Decoded from state so an asynchronous reset drives the line high at once.
    always_comb begin
        txd = 1'b1;
        case (state)
            S_START: txd = 1'b0;
            S_DATA:  txd = shift[0];
            default: txd = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        io_data_read = '0;
        if (sel) begin
            case (reg_idx)
                REG_STATUS:  io_data_read = {16'd0, 8'(count), 4'd0, overflow, empty, full, busy};
                REG_DIVISOR: io_data_read = {16'd0, divisor};
                REG_CTRL:    io_data_read = {31'd0, enable};
                default:     io_data_read = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - directed self-checking bench for io_uart_tx

module tb_io_uart_tx;

    localparam logic [15:0] DEF_DIV = 16'd867;
`ifdef IO_UART_TX_FIFO_EN
    localparam int CAP = 8;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [7:0]  io_addr = '0;
    logic        io_en = 1'b0;
    logic        io_we = 1'b0;
    logic [31:0] io_data_write = '0;
    logic [31:0] io_data_read;
    logic        txd;

    int n_checks = 0;
    int n_fail = 0;

    io_uart_tx dut (
        .clk           (clk),
        .resetb        (resetb),
        .io_addr       (io_addr),
        .io_en         (io_en),
        .io_we         (io_we),
        .io_data_write (io_data_write),
        .io_data_read  (io_data_read),
        .txd           (txd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic io_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        io_addr = a;
        io_data_write = d;
        io_en = 1'b1;
        io_we = 1'b1;
        @(negedge clk);
        io_en = 1'b0;
        io_we = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [31:0] d);
        io_addr = a;
        io_en = 1'b1;
        io_we = 1'b0;
        #1;
        d = io_data_read;
        io_en = 1'b0;
    endtask

    // Expected txd per clock for one frame starting at cycle 0; ones afterwards.
    function automatic logic [63:0] frame_bits(input logic [7:0] b, input int div);
        logic [63:0] f;
        int k;
        f = '1;
        for (int c = 0; c < 64; c++) begin
            k = c / (div + 1);
            if (k == 0) f[c] = 1'b0;
            else if (k <= 8) f[c] = b[k-1];
        end
        return f;
    endfunction

    task automatic capture(input int n, input bit probe, output logic [63:0] line,
                           output logic [63:0] busy);
        logic [31:0] s;
        line = '1;
        busy = '0;
        for (int i = 0; i < n; i++) begin
            line[i] = txd;
            if (probe) begin
                io_read(8'h04, s);
                busy[i] = s[0];
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] s;
        logic [63:0] line;
        logic [63:0] busy;
        logic [63:0] f1;
        logic [63:0] f2;

        // Reset state
        repeat (3) @(negedge clk);
        check("txd_in_reset", 64'(txd), 64'h1);
        resetb = 1'b1;
        io_read(8'h04, s); check("status_rst", 64'(s), 64'h4);
        io_read(8'h08, s); check("divisor_rst", 64'(s), 64'(DEF_DIV));
        io_read(8'h0C, s); check("ctrl_rst", 64'(s), 64'h1);
        io_read(8'h00, s); check("txdata_reads0", 64'(s), 64'h0);

        // Decode and register width
        io_write(8'h08, 32'hABCD_0003);
        io_read(8'h08, s); check("divisor_upper0", 64'(s), 64'h3);
        io_write(8'h18, 32'h7);
        io_read(8'h08, s); check("unselected_wr", 64'(s), 64'h3);
        io_read(8'h14, s); check("unselected_rd", 64'(s), 64'h0);

        // 0x55 at 4 clocks per bit
        io_write(8'h00, 32'h55);
        @(negedge clk);
        capture(40, 1'b1, line, busy);
        check("frame_55", line, frame_bits(8'h55, 3));
        check("busy_55", busy, 64'h0000_00FF_FFFF_FFFF);
        io_read(8'h04, s); check("status_after_55", 64'(s), 64'h4);

        // Back-to-back frames at 1 clock per bit
        io_write(8'h08, 32'h0);
        @(negedge clk);
        io_addr = 8'h00; io_data_write = 32'hA5; io_en = 1'b1; io_we = 1'b1;
        @(negedge clk);
        io_data_write = 32'h3C;
        @(negedge clk);
        io_en = 1'b0; io_we = 1'b0;
        capture(20, 1'b0, line, busy);
        f1 = frame_bits(8'hA5, 0);
        f2 = frame_bits(8'h3C, 0);
        check("frames_a5_3c", line, {f2[53:0], f1[9:0]});
        io_read(8'h04, s); check("status_after_2", 64'(s), 64'h4);

        // Overflow with serialiser disabled
        io_write(8'h0C, 32'h0);
        for (int i = 0; i < CAP + 1; i++) io_write(8'h00, 32'(8'h10 + 8'(i)));
        io_read(8'h04, s); check("status_ovf", 64'(s), 64'(CAP * 256 + 10));
        io_write(8'h04, 32'h0);
        io_read(8'h04, s); check("status_ovf_clr", 64'(s), 64'(CAP * 256 + 2));
        io_write(8'h0C, 32'h1);
        @(negedge clk);
        for (int f = 0; f < CAP; f++) begin
            capture(10, 1'b0, line, busy);
            check("ovf_frame", line, frame_bits(8'h10 + 8'(f), 0) | ~64'h3FF);
        end
        capture(5, 1'b0, line, busy);
        check("ovf_idle", line, '1);
        io_read(8'h04, s); check("status_ovf_done", 64'(s), 64'h4);

        // Flush during the first frame
        io_write(8'h08, 32'h3);
        io_write(8'h0C, 32'h0);
        io_write(8'h00, 32'hC3);
        io_write(8'h0C, 32'h1);
        @(negedge clk);
        fork
            capture(60, 1'b0, line, busy);
            begin
                logic [31:0] q;
                io_write(8'h00, 32'h5A);
`ifdef IO_UART_TX_FIFO_EN
                io_write(8'h00, 32'h96);
`endif
                io_read(8'h04, q);
                check("status_queued", 64'(q), (CAP == 8) ? 64'h201 : 64'h103);
                io_write(8'h0C, 32'h3);
            end
        join
        check("flush_frame", line, frame_bits(8'hC3, 3));
        io_read(8'h04, s); check("status_flushed", 64'(s), 64'h4);
        io_read(8'h0C, s); check("ctrl_after_flush", 64'(s), 64'h1);

        // Asynchronous reset mid-DATA
        io_write(8'h00, 32'h00);
        io_write(8'h00, 32'hFF);
        repeat (8) @(negedge clk);
        check("txd_data_low", 64'(txd), 64'h0);
        #2;
        resetb = 1'b0;
        #1;
        check("txd_async_rst", 64'(txd), 64'h1);
        @(negedge clk);
        resetb = 1'b1;
        io_read(8'h04, s); check("status_post_rst", 64'(s), 64'h4);
        io_read(8'h08, s); check("divisor_post_rst", 64'(s), 64'(DEF_DIV));
        capture(30, 1'b0, line, busy);
        check("no_frame_post_rst", line, '1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/io_uart_tx.md
# io_uart_tx

IO-mapped UART transmitter that sits on the MMU's IO port as a bus responder. It decodes `io_addr`/`io_en`/`io_we` driven by the MMU on behalf of core loads and stores. It buffers bytes written by software and serialises them 8N1, LSB first, on `txd` at a programmable bit rate. It is the device end of the IO interface the core bench currently models as a flat memory array.

## Interface
- `BASE_ADDR`, default 8'h00: block selected when `io_addr[7:4] == BASE_ADDR[7:4]`.
- `DEFAULT_DIV`, default 16'd867: reset value of DIVISOR (clocks per bit minus 1).
- `FIFO_AW`, default 3: FIFO address width, depth 2**FIFO_AW. Used only with `IO_UART_TX_FIFO_EN`.

Ports:
- `clk` input 1: single clock, all state on rising edge.
- `resetb` input 1: asynchronous, active-low reset.
- `io_addr` input 8: byte address from MMU; `[3:2]` selects the register, `[1:0]` ignored.
- `io_en` input 1: access strobe.
- `io_we` input 1: write when high, read when low (qualified by `io_en`).
- `io_data_write` input 32: write data.
- `io_data_read` output 32: read data, combinational.
- `txd` output 1: serial line, idle high.

## Operation
- Register map, offset from base:
  - 0x0 TXDATA (W): push `io_data_write[7:0]`. Reads as 0.
  - 0x4 STATUS (R): `[0]` busy (serialiser not IDLE), `[1]` full, `[2]` empty, `[3]` overflow (sticky), `[15:8]` FIFO count. Any write clears overflow.
  - 0x8 DIVISOR (R/W): `[15:0]`. Upper bits read 0.
  - 0xC CTRL (R/W): `[0]` enable (reset 1). `[1]` flush: write-1 pulse, self-clearing, reads 0.
- `io_data_read` is 0 when the block is not selected, independent of `io_en`.
- Writes take effect at the rising edge when `io_en & io_we` and the block is selected. Reads have no side effects.
- Push when full: byte dropped and overflow set. A push in the same cycle as a pop is accepted even if full.
- Flush empties the FIFO and does not abort the frame in flight. Flush wins over a simultaneous push.
- Serialiser FSM: IDLE, START, DATA, STOP.
  - IDLE -> START when enable=1 and FIFO not empty. The byte is popped on this transition.
  - START: `txd`=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP.
  - STOP: `txd`=1 for one bit period. If enable=1 and FIFO not empty, go directly to START (pop on this transition); otherwise go to IDLE.
- Bit period = DIVISOR+1 clocks. The bit counter reloads from DIVISOR at each bit boundary, so a mid-frame DIVISOR write applies from the next bit. DIVISOR=0 gives 1 clock per bit.
- Clearing enable mid-frame: the current frame completes, then the serialiser stays in IDLE.

## Timing
- Reset values: `txd`=1, FSM=IDLE, FIFO empty, overflow=0, DIVISOR=`DEFAULT_DIV`, enable=1. `io_data_read` follows `io_addr` combinationally; STATUS reads 0x00000004.
- Push-to-start latency from IDLE:
  - Write edge at cycle N.
  - FIFO not empty from N+1.
  - FSM leaves IDLE at edge N+1.
  - `txd` falls after edge N+1.
- Frame length is 10×(DIVISOR+1) clocks. Back-to-back frames have no idle gap.
- The STATUS count reflects a push or pop on the cycle after the edge.
- Asserting `resetb` mid-frame forces `txd`=1 and IDLE immediately (asynchronous) and loses FIFO contents.

## Configuration
- `IO_UART_TX_FIFO_EN` defined: FIFO of depth 2**`FIFO_AW`.
- Undefined: a single-entry holding register replaces the FIFO.
  - Full when one byte is held; count is 0 or 1.
  - `FIFO_AW` is ignored.
  - All other behaviour, including overflow and flush, is unchanged.

## Test plan
- Reset with `resetb`=0 -> `txd`=1; read 0x4 = 0x00000004; read 0x8 = `DEFAULT_DIV`; read 0xC = 0x1.
- DIVISOR=3, write 0x55 to 0x0 -> `txd` shows low for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then high for 4 clocks. Total 40 clocks; busy=1 throughout.
- DIVISOR=0, write 0xA5 then 0x3C on consecutive cycles -> two frames of 10 clocks each with no idle gap; STATUS empty=1 and busy=0 after 20 clocks.
- With FIFO_EN and FIFO_AW=3, enable=0, push 9 bytes -> count=8, full=1, overflow=1. Write STATUS -> overflow=0. Set enable=1 -> 8 frames are sent.
- Flush during frame 1 of 3 queued bytes -> frame 1 completes, `txd` stays high after it, count=0.
- Assert `resetb` mid-DATA -> `txd`=1 asynchronously; after release STATUS reads 0x00000004 and no frame is emitted.
